// File: rtl/block_xfer_ctrl.sv
// block_xfer_ctrl: HuC6280 block-transfer sequencer (TII/TDD/TIN/TIA/TAI), one read + one write per byte.
// Define BLKXFER_TIMING_EN for cycle-accurate SETUP/WAIT idle states; default build runs 2 cycles/byte.
module block_xfer_ctrl #(
  parameter int SETUP_CYCLES = 17,
  parameter int WAIT_CYCLES  = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        RDY,
  input  logic        start,
  input  logic [2:0]  mode,
  input  logic [15:0] src_in,
  input  logic [15:0] dst_in,
  input  logic [15:0] len_in,
  input  logic [7:0]  d_in,
  output logic [15:0] VADDR,
  output logic        rd_en,
  output logic        wr_en,
  output logic [7:0]  d_out,
  output logic        busy,
  output logic        done
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_READ  = 3'd2,
    ST_WRITE = 3'd3,
    ST_WAIT  = 3'd4,
    ST_DONE  = 3'd5
  } state_t;

  localparam logic [2:0] MODE_TII = 3'd0;
  localparam logic [2:0] MODE_TDD = 3'd1;
  localparam logic [2:0] MODE_TIN = 3'd2;
  localparam logic [2:0] MODE_TIA = 3'd3;
  localparam logic [2:0] MODE_TAI = 3'd4;

  // The idle-state timer is 8 bits wide, so both phases must fit in 1..256 cycles.
  if (SETUP_CYCLES < 1 || SETUP_CYCLES > 256 || WAIT_CYCLES < 1 || WAIT_CYCLES > 256) begin : g_bad_params
    $error("block_xfer_ctrl: SETUP_CYCLES and WAIT_CYCLES must be in 1..256");
  end

  state_t      state_q, state_d;
  logic [15:0] src_q, src_d;
  logic [15:0] dst_q, dst_d;
  logic [16:0] cnt_q, cnt_d;
  logic        alt_q, alt_d;
  logic [2:0]  mode_q, mode_d;
  logic [7:0]  databuf_q, databuf_d;
  logic [15:0] vaddr_q, vaddr_d;
  logic        rd_en_q, rd_en_d;
  logic        wr_en_q, wr_en_d;
  logic [7:0]  d_out_q, d_out_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
`ifdef BLKXFER_TIMING_EN
  logic [7:0]  timer_q, timer_d;
`endif

  function automatic logic [15:0] offset_addr(input logic [15:0] base, input logic bump);
    return base + {15'd0, bump};
  endfunction

  function automatic logic [2:0] norm_mode(input logic [2:0] m);
    return (m > MODE_TAI) ? MODE_TII : m;
  endfunction

  // Sequencer next state and pointer/counter updates; RDY=0 leaves every register as is.
  always_comb begin
    state_d   = state_q;
    src_d     = src_q;
    dst_d     = dst_q;
    cnt_d     = cnt_q;
    alt_d     = alt_q;
    mode_d    = mode_q;
    databuf_d = databuf_q;
`ifdef BLKXFER_TIMING_EN
    timer_d   = timer_q;
`endif
    if (RDY) begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            src_d  = src_in;
            dst_d  = dst_in;
            mode_d = norm_mode(mode);
            cnt_d  = (len_in == 16'd0) ? 17'h1_0000 : {1'b0, len_in};
            alt_d  = 1'b0;
`ifdef BLKXFER_TIMING_EN
            timer_d = 8'(SETUP_CYCLES - 1);
            state_d = ST_SETUP;
`else
            state_d = ST_READ;
`endif
          end else begin
            state_d = ST_IDLE;
          end
        end
`ifdef BLKXFER_TIMING_EN
        ST_SETUP: begin
          if (timer_q == 8'd0) begin
            state_d = ST_READ;
          end else begin
            timer_d = timer_q - 8'd1;
          end
        end
        ST_WAIT: begin
          if (timer_q == 8'd0) begin
            state_d = (cnt_q == 17'd0) ? ST_DONE : ST_READ;
          end else begin
            timer_d = timer_q - 8'd1;
          end
        end
`endif
        ST_READ: begin
          databuf_d = d_in;
          state_d   = ST_WRITE;
        end
        ST_WRITE: begin
          case (mode_q)
            MODE_TDD: begin
              src_d = src_q - 16'd1;
              dst_d = dst_q - 16'd1;
            end
            MODE_TIN: src_d = src_q + 16'd1;
            MODE_TIA: begin
              src_d = src_q + 16'd1;
              alt_d = ~alt_q;
            end
            MODE_TAI: begin
              dst_d = dst_q + 16'd1;
              alt_d = ~alt_q;
            end
            default: begin
              src_d = src_q + 16'd1;
              dst_d = dst_q + 16'd1;
            end
          endcase
          cnt_d = cnt_q - 17'd1;
`ifdef BLKXFER_TIMING_EN
          timer_d = 8'(WAIT_CYCLES - 1);
          state_d = ST_WAIT;
`else
          state_d = (cnt_q == 17'd1) ? ST_DONE : ST_READ;
`endif
        end
        ST_DONE: state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end else begin
      state_d = state_q;
    end
  end

  // Outputs are decoded from the next state so they register alongside it.
  always_comb begin
    case (state_d)
      ST_READ:  vaddr_d = offset_addr(src_d, alt_d && (mode_d == MODE_TAI));
      ST_WRITE: vaddr_d = offset_addr(dst_d, alt_d && (mode_d == MODE_TIA));
      default:  vaddr_d = 16'h0000;
    endcase
    rd_en_d = (state_d == ST_READ);
    wr_en_d = (state_d == ST_WRITE);
    d_out_d = databuf_d;
    busy_d  = (state_d != ST_IDLE);
    done_d  = (state_d == ST_DONE);
  end

  // State, datapath and output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      src_q     <= 16'h0000;
      dst_q     <= 16'h0000;
      cnt_q     <= 17'h0_0000;
      alt_q     <= 1'b0;
      mode_q    <= 3'd0;
      databuf_q <= 8'h00;
      vaddr_q   <= 16'h0000;
      rd_en_q   <= 1'b0;
      wr_en_q   <= 1'b0;
      d_out_q   <= 8'h00;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
`ifdef BLKXFER_TIMING_EN
      timer_q   <= 8'd0;
`endif
    end else begin
      state_q   <= state_d;
      src_q     <= src_d;
      dst_q     <= dst_d;
      cnt_q     <= cnt_d;
      alt_q     <= alt_d;
      mode_q    <= mode_d;
      databuf_q <= databuf_d;
      vaddr_q   <= vaddr_d;
      rd_en_q   <= rd_en_d;
      wr_en_q   <= wr_en_d;
      d_out_q   <= d_out_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
`ifdef BLKXFER_TIMING_EN
      timer_q   <= timer_d;
`endif
    end
  end

  assign VADDR = vaddr_q;
  assign rd_en = rd_en_q;
  assign wr_en = wr_en_q;
  assign d_out = d_out_q;
  assign busy  = busy_q;
  assign done  = done_q;

endmodule
